// File: rtl/ctrl_sequencer.sv
// Microprogram sequencer: plays a writable control-word memory onto ctrl_bus,
// one word per clock, for a latched number of passes, with start/busy/done.
module ctrl_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [CW-1:0]    prog_data,
  input  logic [AW-1:0]    prog_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             start,
  input  logic             abort,
  output logic [CW-1:0]    ctrl_bus,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pc,
  output logic [REP_W-1:0] pass_cnt
);

  // Handshake: start is level-sampled and only accepted in IDLE; busy is high
  // for every cycle a program word is on ctrl_bus; done pulses for one cycle
  // after the last word of the last pass (never after abort or reset).
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     mem [DEPTH];
  logic [AW-1:0]     len, len_nx;
  logic [REP_W-1:0]  passes, passes_nx;
  logic [CW-1:0]     ctrl_nx;
  logic [AW-1:0]     pc_nx, pc_inc;
  logic [REP_W-1:0]  pass_nx;
  logic              busy_nx, done_nx;

  assign pc_inc = pc + AW'(1);

  // Program memory has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE) && !start) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_nx  = state;
    ctrl_nx   = ctrl_bus;
    pc_nx     = pc;
    pass_nx   = pass_cnt;
    len_nx    = len;
    passes_nx = passes;
    case (state)
      S_IDLE: begin
        ctrl_nx = '0;
        if (start) begin
          len_nx    = prog_len;
          passes_nx = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
          pc_nx     = '0;
          pass_nx   = '0;
          ctrl_nx   = mem[0];
          state_nx  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          ctrl_nx  = '0;
          pc_nx    = '0;
          pass_nx  = '0;
          state_nx = S_IDLE;
        end else if (pc < len) begin
          pc_nx   = pc_inc;
          ctrl_nx = mem[pc_inc];
        end else if (pass_cnt < passes - REP_W'(1)) begin
          // Wrap straight back to word 0 so passes run back to back.
          pc_nx   = '0;
          pass_nx = pass_cnt + REP_W'(1);
          ctrl_nx = mem[0];
        end else begin
          ctrl_nx  = '0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        ctrl_nx  = '0;
        pc_nx    = '0;
        pass_nx  = '0;
        state_nx = S_IDLE;
      end
      default: begin
        ctrl_nx  = '0;
        pc_nx    = '0;
        pass_nx  = '0;
        state_nx = S_IDLE;
      end
    endcase
    busy_nx = (state_nx == S_RUN);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ctrl_bus <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc       <= '0;
      pass_cnt <= '0;
      len      <= '0;
      passes   <= REP_W'(1);
    end else begin
      state    <= state_nx;
      ctrl_bus <= ctrl_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      pc       <= pc_nx;
      pass_cnt <= pass_nx;
      len      <= len_nx;
      passes   <= passes_nx;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a run-list model expands each accepted start into
// the full word stream; every negedge compares the DUT against it.
module tb_ctrl_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             prog_we = 1'b0;
  logic [AW-1:0]    prog_addr = '0;
  logic [CW-1:0]    prog_data = '0;
  logic [AW-1:0]    prog_len = '0;
  logic [REP_W-1:0] rep_cnt = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CW-1:0]    ctrl_bus;
  logic             busy, done;
  logic [AW-1:0]    pc;
  logic [REP_W-1:0] pass_cnt;

  ctrl_sequencer #(.DEPTH(DEPTH), .AW(AW), .CW(CW), .REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .rep_cnt(rep_cnt),
    .start(start), .abort(abort), .ctrl_bus(ctrl_bus), .busy(busy),
    .done(done), .pc(pc), .pass_cnt(pass_cnt)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each queue entry is one cycle of the run: {word, address, pass}.
  logic [CW+AW+REP_W-1:0] exp_q[$];
  logic [CW-1:0]    m_mem [DEPTH];
  logic [CW-1:0]    e_ctrl = '0;
  logic             e_busy = 1'b0;
  logic             e_done = 1'b0;
  logic [AW-1:0]    e_pc = '0;
  logic [REP_W-1:0] e_pass = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      e_ctrl <= '0; e_busy <= 1'b0; e_done <= 1'b0; e_pc <= '0; e_pass <= '0;
    end else if (e_busy) begin
      if (abort) begin
        exp_q.delete();
        e_ctrl <= '0; e_busy <= 1'b0; e_pc <= '0; e_pass <= '0;
      end else if (exp_q.size() > 0) begin
        e_ctrl <= exp_q[0][CW+AW+REP_W-1:AW+REP_W];
        e_pc   <= exp_q[0][AW+REP_W-1:REP_W];
        e_pass <= exp_q[0][REP_W-1:0];
        void'(exp_q.pop_front());
      end else begin
        e_ctrl <= '0; e_busy <= 1'b0; e_done <= 1'b1;
      end
    end else if (e_done) begin
      e_ctrl <= '0; e_done <= 1'b0; e_pc <= '0; e_pass <= '0;
    end else if (start) begin
      for (int p = 0; p < ((rep_cnt == '0) ? 1 : int'(rep_cnt)); p++)
        for (int a = 0; a <= int'(prog_len); a++)
          exp_q.push_back({m_mem[a], AW'(a), REP_W'(p)});
      e_ctrl <= exp_q[0][CW+AW+REP_W-1:AW+REP_W];
      e_pc   <= exp_q[0][AW+REP_W-1:REP_W];
      e_pass <= exp_q[0][REP_W-1:0];
      e_busy <= 1'b1;
      void'(exp_q.pop_front());
    end else if (prog_we) begin
      m_mem[prog_addr] <= prog_data;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int n_checks = 0;
  int n_errors = 0;
  int tmo_seen = 0;
  int tmo_rep  = 0;
  event rst_chk_ev;
  logic rst_chk = 1'b0;
  logic pin_en = 1'b0;
  logic [CW-1:0]    pin_ctrl = '0;
  logic             pin_done = 1'b0, pin_busy = 1'b0;
  logic [AW-1:0]    pin_pc = '0;
  logic [REP_W-1:0] pin_pass = '0;
  string            pin_name = "";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or rst_chk_ev);
      if (tmo_seen != tmo_rep) begin
        chk("run_timeout", 32'(tmo_seen), 32'(tmo_rep));
        tmo_rep = tmo_seen;
      end
      if (rst_chk) begin
        chk("rst_ctrl", 32'(ctrl_bus), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_pass", 32'(pass_cnt), 32'h0);
      end else if (rst_n) begin
        chk("model_ctrl", 32'(ctrl_bus), 32'(e_ctrl));
        chk("model_busy", 32'(busy), 32'(e_busy));
        chk("model_done", 32'(done), 32'(e_done));
        chk("model_pc", 32'(pc), 32'(e_pc));
        chk("model_pass", 32'(pass_cnt), 32'(e_pass));
        if (pin_en) begin
          chk({pin_name, "_ctrl"}, 32'(ctrl_bus), 32'(pin_ctrl));
          chk({pin_name, "_done"}, 32'(done), 32'(pin_done));
          chk({pin_name, "_busy"}, 32'(busy), 32'(pin_busy));
          chk({pin_name, "_pc"}, 32'(pc), 32'(pin_pc));
          chk({pin_name, "_pass"}, 32'(pass_cnt), 32'(pin_pass));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [AW-1:0] a, input logic [CW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Hand-computed expectation for the next cycle; clears one-shot inputs.
  task automatic pin(input string nm, input logic [CW-1:0] c, input logic d,
                     input logic b, input logic [AW-1:0] p, input logic [REP_W-1:0] ps);
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    pin_name = nm; pin_ctrl = c; pin_done = d; pin_busy = b; pin_pc = p; pin_pass = ps;
    pin_en = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin_base_run(input string nm);
    start = 1'b1;
    pin(nm, 8'h41, 1'b0, 1'b1, 4'd0, 4'd0);
    pin(nm, 8'h8A, 1'b0, 1'b1, 4'd1, 4'd0);
    pin(nm, 8'h23, 1'b0, 1'b1, 4'd2, 4'd0);
    pin(nm, 8'h00, 1'b1, 1'b0, 4'd2, 4'd0);
    pin(nm, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic random_run(input int r);
    int k;
    int guard;
    k = $urandom_range(0, 6);
    for (int i = 0; i < k; i++) write_word(AW'($urandom), CW'($urandom));
    prog_len = AW'($urandom_range(0, 15));
    rep_cnt  = (r % 8 == 7) ? 4'd15 : REP_W'($urandom_range(0, 4));
    start = 1'b1; prog_we = 1'($urandom_range(0, 1));
    prog_addr = AW'($urandom); prog_data = CW'($urandom);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    guard = 0;
    while ((busy || done) && guard < 400) begin
      abort     = ($urandom_range(0, 63) == 0);
      start     = 1'($urandom_range(0, 1));
      prog_we   = 1'($urandom_range(0, 1));
      prog_addr = AW'($urandom);
      prog_data = CW'($urandom);
      prog_len  = AW'($urandom);
      rep_cnt   = REP_W'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) tmo_seen++;
    abort = 1'b0; start = 1'b0; prog_we = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    rst_chk = 1'b1; -> rst_chk_ev; #1 rst_chk = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 8'h00);

    // Basic three-word program, single pass
    write_word(4'd0, 8'h41); write_word(4'd1, 8'h8A); write_word(4'd2, 8'h23);
    prog_len = 4'd2; rep_cnt = 4'd1;
    pin_base_run("basic");

    // Three passes back to back
    rep_cnt = 4'd3; start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pin("rep3", 8'h41, 1'b0, 1'b1, 4'd0, REP_W'(p));
      pin("rep3", 8'h8A, 1'b0, 1'b1, 4'd1, REP_W'(p));
      pin("rep3", 8'h23, 1'b0, 1'b1, 4'd2, REP_W'(p));
    end
    pin("rep3", 8'h00, 1'b1, 1'b0, 4'd2, 4'd2);
    pin("rep3", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);

    rep_cnt = 4'd0;
    pin_base_run("rep0");

    // Abort while 0x8A is on the bus
    rep_cnt = 4'd1; start = 1'b1;
    pin("abort", 8'h41, 1'b0, 1'b1, 4'd0, 4'd0);
    pin("abort", 8'h8A, 1'b0, 1'b1, 4'd1, 4'd0);
    abort = 1'b1;
    pin("abort", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
    pin("abort", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
    pin_base_run("after_abort");

    // Asynchronous reset mid-run, memory retained
    start = 1'b1;
    pin("rst_run", 8'h41, 1'b0, 1'b1, 4'd0, 4'd0);
    pin("rst_run", 8'h8A, 1'b0, 1'b1, 4'd1, 4'd0);
    #2 rst_n = 1'b0;
    #1 rst_chk = 1'b1; -> rst_chk_ev;
    #1 rst_chk = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    pin_base_run("after_rst");

    // Writes, start and prog_len changes during RUN are ignored
    start = 1'b1;
    pin("run_ign", 8'h41, 1'b0, 1'b1, 4'd0, 4'd0);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'hFF; start = 1'b1; prog_len = 4'd0;
    pin("run_ign", 8'h8A, 1'b0, 1'b1, 4'd1, 4'd0);
    pin("run_ign", 8'h23, 1'b0, 1'b1, 4'd2, 4'd0);
    pin("run_ign", 8'h00, 1'b1, 1'b0, 4'd2, 4'd0);
    pin("run_ign", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
    prog_len = 4'd2;
    pin_base_run("replay");

    // Single-word program
    write_word(4'd0, 8'hC5);
    prog_len = 4'd0; rep_cnt = 4'd1; start = 1'b1;
    pin("len0", 8'hC5, 1'b0, 1'b1, 4'd0, 4'd0);
    pin("len0", 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);
    pin("len0", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);

    // Full memory
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), CW'(i * 17 + 3));
    prog_len = 4'd15; start = 1'b1;
    for (int i = 0; i < DEPTH; i++) pin("full", CW'(i * 17 + 3), 1'b0, 1'b1, AW'(i), 4'd0);
    pin("full", 8'h00, 1'b1, 1'b0, 4'd15, 4'd0);
    pin("full", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);

    // Randomized runs against the model
    for (int r = 0; r < 40; r++) random_run(r);

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Microprogram sequencer that drives the 8-bit control word consumed by the ALU/mux/shift/register datapath.
- Bit layout of the word: [2:0] ALU op, [3] mux select, [5:4] shift op, [6] Q enable, [7] R enable.
- Holds a small writable program memory and plays it out one word per clock for a programmable number of passes, with a start/busy/done handshake.
- Sits beside the datapath; ctrl_bus connects directly to the datapath control input.

Parameters:
- DEPTH, 16, number of program memory words.
- AW, 4, address width (log2 DEPTH).
- CW, 8, control word width.
- REP_W, 4, width of pass count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  AW  write address.
- prog_data  in  CW  write data.
- prog_len  in  AW  index of last program word (program length minus 1).
- rep_cnt  in  REP_W  number of passes; 0 is treated as 1.
- start  in  1  run request, level-sampled.
- abort  in  1  terminate run.
- ctrl_bus  out  CW  registered control word to datapath.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- pc  out  AW  address of word currently on ctrl_bus.
- pass_cnt  out  REP_W  current pass index, 0-based.

Behaviour:
- States: IDLE, RUN, DONE.
- Async reset while rst_n=0:
  - state=IDLE; ctrl_bus=0x00, busy=0, done=0, pc=0, pass_cnt=0.
  - Program memory is not reset; its contents survive reset.
- Reset mid-run forces the outputs above immediately, with no done pulse.
- All outputs are registered.
- Memory write: on the clock edge, if prog_we=1 and state=IDLE and start=0, mem[prog_addr] <= prog_data. Writes in RUN or DONE, or in the cycle start is accepted, are ignored.
- IDLE:
  - ctrl_bus=0x00 (no register enables, so the datapath holds).
  - On an edge with start=1:
    - latch len=prog_len and passes=max(rep_cnt,1);
    - pc<=0, pass_cnt<=0, ctrl_bus<=mem[0], state<=RUN.
- RUN: each edge, in priority order:
  - abort=1 -> ctrl_bus<=0x00, pc<=0, pass_cnt<=0, state<=IDLE, no done.
  - pc<len -> pc<=pc+1, ctrl_bus<=mem[pc+1].
  - pc==len and pass_cnt<passes-1 -> pc<=0, pass_cnt<=pass_cnt+1, ctrl_bus<=mem[0] (wrap with no bubble).
  - pc==len and final pass -> ctrl_bus<=0x00, done<=1, state<=DONE.
- DONE:
  - Lasts exactly one cycle; done=1 and busy=0 during it.
  - Next edge: done<=0, pc<=0, pass_cnt<=0, state<=IDLE.
  - start in DONE is ignored; it must be re-presented in IDLE.
- busy=1 exactly while state=RUN. start while busy is ignored.
- Latency and duration:
  - The first word appears on ctrl_bus one clock after the start edge.
  - Each word is held exactly one cycle.
  - The run occupies (len+1)*passes cycles, followed by the one-cycle done pulse.
- Changes to prog_len or rep_cnt during RUN have no effect; the latched values apply.
- Boundaries:
  - prog_len=0 gives single-word passes.
  - pc wraps only at len, never past DEPTH-1; len=DEPTH-1 uses the full memory.
  - rep_cnt=2^REP_W-1 runs that many passes with no overflow; pass_cnt tops out at passes-1.

Test Plan:
- Load 0x41@0, 0x8A@1, 0x23@2; prog_len=2, rep_cnt=1; pulse start -> ctrl_bus 0x41, 0x8A, 0x23 on 3 consecutive cycles with pc 0,1,2 and busy=1; next cycle ctrl_bus=0x00 with done=1 for exactly 1 cycle; then IDLE.
- Same program, rep_cnt=3 -> 9-cycle stream 41,8A,23 repeated with pass_cnt 0,0,0,1,1,1,2,2,2, no idle bubble at wraps, a single done pulse; rep_cnt=0 behaves identically to rep_cnt=1.
- Start the run, assert abort while ctrl_bus=0x8A -> next cycle ctrl_bus=0x00, busy=0; done never asserts; a new start replays from 0x41.
- Drive rst_n low while ctrl_bus=0x8A -> ctrl_bus=0x00, busy=0, pc=0 without a clock edge; release and start -> 0x41,0x8A,0x23 again (memory retained).
- During RUN: prog_we to addr 1 with 0xFF, start re-pulsed, prog_len changed to 0 -> all ignored; run completes 41,8A,23 and the later replay still shows 0x8A at addr 1.
- prog_len=0, mem[0]=0xC5, rep_cnt=1 -> one cycle of 0xC5 then done; prog_len=15 with all 16 words loaded -> 16 distinct words in address order.
